// File: rtl/alu_sweep_pkg.sv
// alu_sweep_pkg: shared state enum, slice opcodes and vector bit positions for the ALU slice sweeper
package alu_sweep_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, ADVANCE, FINISH} state_e;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;
  localparam int VEC_A  = 0;
  localparam int VEC_B  = 1;
  localparam int VEC_CN = 2;
  localparam int VEC_S  = 3;
  localparam int VEC_W  = 6;
  localparam logic [VEC_W-1:0] VEC_LAST = '1;
endpackage

// File: rtl/alu_slice_model.sv
// alu_slice_model: combinational golden model of the 1-bit ALU slice
module alu_slice_model
  import alu_sweep_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cn,
  input  logic [2:0] s,
  output logic       y_exp,
  output logic       c_exp
);
  logic [1:0] add, sub;
  assign add = {1'b0, a} + {1'b0, b} + {1'b0, cn};
  assign sub = {1'b0, a} + {1'b0, ~b} + {1'b0, cn};
  always_comb begin
    {c_exp, y_exp} = 2'b00;
    case (s)
      OP_AND:  y_exp = a & b;
      OP_OR:   y_exp = a | b;
      OP_XOR:  y_exp = a ^ b;
      OP_NOR:  y_exp = ~(a | b);
      OP_ADD:  {c_exp, y_exp} = add;
      OP_SUB:  {c_exp, y_exp} = sub;
      OP_NOTA: y_exp = ~a;
      OP_PASS: y_exp = a;
      default: {c_exp, y_exp} = 2'b00;
    endcase
  end
endmodule

// File: rtl/alu_slice_sweeper.sv
// alu_slice_sweeper: sweeps all 64 slice input vectors and checks y/cn_1 when ALU_SWEEP_CHECK_EN is defined
module alu_slice_sweeper
  import alu_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] vec,
  output logic             a,
  output logic             b,
  output logic             cn,
  output logic [2:0]       s,
  input  logic             y,
  input  logic             cn_1,
  output logic [6:0]       err_cnt,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);
  state_e state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic [VEC_W-1:0] vec_q, vec_d, fail_vec_q, fail_vec_d;
  logic [6:0] err_q, err_d;
  logic busy_q, busy_d, done_q, done_d, fv_q, fv_d, mismatch;
`ifdef ALU_SWEEP_CHECK_EN
  logic y_exp, c_exp;
  alu_slice_model u_model (
    .a(vec_q[VEC_A]), .b(vec_q[VEC_B]), .cn(vec_q[VEC_CN]), .s(vec_q[VEC_S+:3]),
    .y_exp(y_exp), .c_exp(c_exp)
  );
  assign mismatch = (y != y_exp) || (cn_1 != c_exp);
`else
  // Without checking the result registers never leave their reset value of 0.
  logic unused_slice;
  assign unused_slice = y ^ cn_1;
  assign mismatch = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    settle_d = settle_q;
    vec_d = vec_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    fv_d = fv_q;
    fail_vec_d = fail_vec_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = DRIVE;
        settle_d = '0;
        vec_d = '0;
        busy_d = 1'b1;
        err_d = '0;
        fv_d = 1'b0;
        fail_vec_d = '0;
      end
      DRIVE: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == 8'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
          settle_d = '0;
        end
      end
      SAMPLE: begin
        err_d = mismatch ? err_q + 7'd1 : err_q;
        fv_d = fv_q | mismatch;
        fail_vec_d = (mismatch && !fv_q) ? vec_q : fail_vec_q;
        state_d = (vec_q == VEC_LAST) ? FINISH : ADVANCE;
        busy_d = vec_q != VEC_LAST;
        done_d = vec_q == VEC_LAST;
      end
      ADVANCE: begin
        vec_d = vec_q + 1'b1;
        state_d = DRIVE;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      settle_q <= '0;
      vec_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= '0;
      fv_q <= 1'b0;
      fail_vec_q <= '0;
    end else begin
      state_q <= state_d;
      settle_q <= settle_d;
      vec_q <= vec_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      fv_q <= fv_d;
      fail_vec_q <= fail_vec_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign vec = vec_q;
  assign {s, cn, b, a} = vec_q;
  assign err_cnt = err_q;
  assign fail_valid = fv_q;
  assign fail_vec = fail_vec_q;
endmodule

// File: tb/tb_alu_slice_sweeper.sv
// tb_alu_slice_sweeper: randomized self-checking bench with a faulty-slice stand-in and arithmetic reference model
module tb_alu_slice_sweeper;
  localparam int SC = 4;
  localparam int PER = SC + 2;
  localparam int LAT = 64 * PER;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, a, b, cn, y, cn_1, fail_valid;
  logic [5:0] vec, fail_vec;
  logic [2:0] s;
  logic [6:0] err_cnt;
  int checks = 0, fails = 0;
  int mode = 0;
  logic [63:0] fy = '0, fc = '0;

  always #5 clk = ~clk;

  alu_slice_sweeper #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .vec(vec),
    .a(a), .b(b), .cn(cn), .s(s), .y(y), .cn_1(cn_1),
    .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  // {C,Y} straight from the opcode table as integer arithmetic
  function automatic logic [1:0] golden(input logic [5:0] v);
    int av = int'(v[0]), bv = int'(v[1]), cv = int'(v[2]), r;
    case (v[5:3])
      3'd0: r = av & bv;
      3'd1: r = av | bv;
      3'd2: r = av ^ bv;
      3'd3: r = 1 - (av | bv);
      3'd4: r = av + bv + cv;
      3'd5: r = av + (1 - bv) + cv;
      3'd6: r = 1 - av;
      default: r = av;
    endcase
    return 2'(r);
  endfunction

  function automatic logic [1:0] slice_out(input logic [5:0] v, input int m,
                                           input logic [63:0] my, input logic [63:0] mc);
    logic [1:0] g = golden(v);
    if (m == 1) g[1] = 1'b0;
    if (m == 2 && v[5:3] == 3'd2) g[0] = ~g[0];
    if (m == 3) g = g ^ {mc[v], my[v]};
    return g;
  endfunction

  assign {cn_1, y} = slice_out({s, cn, b, a}, mode, fy, fc);

  task automatic do_sweep(input int extra_at, input int rst_at, output int lat,
                          output int seq_errs, output int busy_errs, output bit saw63);
    lat = -1; seq_errs = 0; busy_errs = 0; saw63 = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= LAT + 100; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == extra_at) start = 1'b1;
      if (n == extra_at + 1) start = 1'b0;
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        return;
      end
      if (done) begin
        lat = n;
        if (busy !== 1'b0) busy_errs++;
        break;
      end
      if (vec !== 6'((n - 1) / PER) || {s, cn, b, a} !== vec) seq_errs++;
      if (busy !== 1'b1) busy_errs++;
      if (n % PER == SC + 1 && vec === 6'd63) saw63 = 1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if ({busy, done, vec, err_cnt, fail_valid, fail_vec, s, cn, b, a} !== '0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b done=%b vec=%0d err=%0d fv=%b fvec=%0d slice=%b expected all 0",
               busy, done, vec, err_cnt, fail_valid, fail_vec, {s, cn, b, a});
    end
  endtask

  task automatic test_sweep(input string name, input int m);
    int lat, se, be, exp_err = 0;
    bit saw, exp_fv = 0;
    logic [5:0] exp_fvec = '0;
    mode = m;
    fy = {$urandom, $urandom};
    fc = {$urandom, $urandom} & {$urandom, $urandom};
`ifdef ALU_SWEEP_CHECK_EN
    for (int v = 0; v < 64; v++)
      if (slice_out(6'(v), m, fy, fc) != golden(6'(v))) begin
        if (!exp_fv) exp_fvec = 6'(v);
        exp_fv = 1;
        exp_err++;
      end
`endif
    do_sweep(0, 0, lat, se, be, saw);
    checks++;
    if (lat != LAT) begin fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, LAT); end
    checks++;
    if (se != 0 || be != 0) begin fails++; $display("FAIL %s sequence: vec_errs=%0d busy_errs=%0d want 0", name, se, be); end
    checks++;
    if (!saw || vec !== 6'd63) begin fails++; $display("FAIL %s last_vec: saw63=%0d vec=%0d want 1/63", name, saw, vec); end
    checks++;
    if (err_cnt !== 7'(exp_err)) begin fails++; $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, exp_err); end
    checks++;
    if (fail_valid !== exp_fv || fail_vec !== exp_fvec) begin
      fails++;
      $display("FAIL %s first_fail: got %b/%b want %b/%b", name, fail_valid, fail_vec, exp_fv, exp_fvec);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err_cnt !== 7'(exp_err)) begin
      fails++;
      $display("FAIL %s after_done: done=%b busy=%b err=%0d want 0/0/%0d", name, done, busy, err_cnt, exp_err);
    end
  endtask

  task automatic test_start_ignored_and_reset;
    int lat, se, be;
    bit saw, got_done = 0;
    mode = 1;
    do_sweep(50, 0, lat, se, be, saw);
    checks++;
    if (lat != LAT || se != 0) begin fails++; $display("FAIL busy_start: latency %0d vec_errs %0d want %0d/0", lat, se, LAT); end
    @(negedge clk);
    do_sweep(50, 200, lat, se, be, saw);
    checks++;
    if ({busy, done, vec, err_cnt, fail_valid, fail_vec, s, cn, b, a} !== '0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b done=%b vec=%0d err=%0d fv=%b fvec=%0d want all 0",
               busy, done, vec, err_cnt, fail_valid, fail_vec);
    end
    repeat (3) @(negedge clk) if (done) got_done = 1;
    rst_n = 1'b1;
    repeat (LAT) @(negedge clk) if (done || busy) got_done = 1;
    checks++;
    if (got_done) begin fails++; $display("FAIL reset_abort: done/busy seen after reset, want none"); end
  endtask

  task automatic test_back_to_back;
    int lat, se, be;
    bit saw;
    mode = 0;
    do_sweep(0, 0, lat, se, be, saw);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) begin
      checks++;
      if (busy !== 1'b0 || vec !== 6'd63) begin
        fails++;
        $display("FAIL start_on_done: busy=%b vec=%0d want 0/63", busy, vec);
      end
      @(negedge clk);
    end
    mode = 2;
    do_sweep(0, 0, lat, se, be, saw);
    checks++;
    if (lat != LAT || se != 0 || be != 0) begin
      fails++;
      $display("FAIL restart: latency=%0d vec_errs=%0d busy_errs=%0d want %0d/0/0", lat, se, be, LAT);
    end
  endtask

  initial begin
    test_reset;
    test_sweep("stuck_cn1", 1);
    test_sweep("xor_y_inv", 2);
    test_sweep("golden", 0);
    test_sweep("random_a", 3);
    test_sweep("random_b", 3);
    test_start_ignored_and_reset;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
